// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared index/entry types and round-robin pointer helper for mem_port_arbiter
package mem_arb_pkg;

    localparam int NUM_REQ_DEF    = 2;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int REQ_IDX_W      = (NUM_REQ_DEF > 1) ? $clog2(NUM_REQ_DEF) : 1;

    typedef logic [REQ_IDX_W-1:0] req_idx_t;

    typedef struct packed {
        req_idx_t                  tag;
        logic [DATA_WIDTH_DEF-1:0] data;
    } rsp_entry_t;

    // Pointer moves just past the winner; holds when nobody was granted.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned g,
                                            input int unsigned n, input logic granted);
        if (!granted) begin
            return ptr;
        end
        return ((g + 1) >= n) ? 0 : (g + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with combinational one-hot grant and private pointer
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Search req starting at ptr and wrapping; first asserted request wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (en && !found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Advance the pointer past the winner, hold when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else begin
            ptr <= IDX_W'(rr_next(32'(ptr), 32'(gnt_idx), NUM_REQ, found));
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - dual-port BRAM sharer: RR load/store arbiters, credited load response FIFO (MEM_ARB_PERF_EN adds perf counters)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            ld_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] ld_addr,
    output logic [NUM_REQ-1:0]            ld_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    input  logic [NUM_REQ-1:0]            st_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] st_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] st_data,
    output logic [NUM_REQ-1:0]            st_ready,
    output logic                          ce0,
    output logic                          we0,
    output logic [ADDR_WIDTH-1:0]         address0,
    output logic [DATA_WIDTH-1:0]         dout0,
    input  logic [DATA_WIDTH-1:0]         din0,
    output logic                          ce1,
    output logic                          we1,
    output logic [ADDR_WIDTH-1:0]         address1,
    output logic [DATA_WIDTH-1:0]         dout1,
    input  logic [DATA_WIDTH-1:0]         din1
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]                   perf_ld_stall,
    output logic [31:0]                   perf_ld_conflict
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int CW    = CNT_W + 1;

    logic [IDX_W-1:0]      fifo_tag  [RSP_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [RSP_DEPTH];
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic [CNT_W-1:0]      occ;
    logic                  inflight;
    logic [IDX_W-1:0]      inflight_tag;

    logic                  fifo_nonempty, pop, credit_ok;
    logic [IDX_W-1:0]      head_tag;
    logic [CW-1:0]         used_slots, cap_slots;
    logic [NUM_REQ-1:0]    ld_gnt, st_gnt;
    logic [IDX_W-1:0]      ld_idx, st_idx;
    logic [DATA_WIDTH-1:0] unused_din1;

    assign unused_din1 = din1;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == RSP_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign fifo_nonempty = (occ != '0);
    assign head_tag      = fifo_tag[rd_ptr];
    assign pop           = fifo_nonempty & rsp_ready[head_tag];

    // The in-flight read already owns a slot; a same-cycle pop frees one.
    assign used_slots = CW'(occ) + CW'(inflight);
    assign cap_slots  = CW'(RSP_DEPTH) + CW'(pop);
    assign credit_ok  = used_slots < cap_slots;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_ld_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (ld_valid),
        .en      (rst & credit_ok),
        .gnt     (ld_gnt),
        .gnt_idx (ld_idx)
    );

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_st_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (st_valid),
        .en      (rst),
        .gnt     (st_gnt),
        .gnt_idx (st_idx)
    );

    assign ld_ready = ld_gnt;
    assign ce0      = |ld_gnt;
    assign we0      = 1'b0;
    assign dout0    = '0;
    assign address0 = ce0 ? ld_addr[ld_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;

    assign st_ready = st_gnt;
    assign ce1      = |st_gnt;
    assign we1      = ce1;
    assign address1 = ce1 ? st_addr[st_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign dout1    = ce1 ? st_data[st_idx*DATA_WIDTH +: DATA_WIDTH] : '0;

    assign rsp_data = fifo_nonempty ? fifo_data[rd_ptr] : '0;

    // Present the head entry to its owner only.
    always_comb begin
        rsp_valid = '0;
        if (fifo_nonempty) begin
            rsp_valid[head_tag] = 1'b1;
        end
    end

    // FIFO pointers, occupancy and the one-deep in-flight read tracker.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            occ          <= '0;
            inflight     <= 1'b0;
            inflight_tag <= '0;
        end else begin
            if (inflight) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({inflight, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            inflight     <= ce0;
            inflight_tag <= ld_idx;
        end
    end

    // Capture BRAM read data one cycle after the grant, tagged with its issuer.
    always_ff @(posedge clk) begin
        if (inflight) begin
            fifo_tag[wr_ptr]  <= inflight_tag;
            fifo_data[wr_ptr] <= din0;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic any_ld, multi_ld;
    assign any_ld   = |ld_valid;
    assign multi_ld = ($countones(ld_valid) > 1);

    // Saturating counters for starved and contended load cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_ld_stall    <= '0;
            perf_ld_conflict <= '0;
        end else begin
            if (any_ld && !ce0 && (perf_ld_stall != '1)) begin
                perf_ld_stall <= perf_ld_stall + 1'b1;
            end
            if (multi_ld && (perf_ld_conflict != '1)) begin
                perf_ld_conflict <= perf_ld_conflict + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized and directed bench for mem_port_arbiter with queue-based reference model (MEM_ARB_PERF_EN aware)
module tb_mem_port_arbiter;

    localparam int NR    = 2;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  ld_valid, ld_ready, rsp_valid, rsp_ready, st_valid, st_ready;
    logic [63:0] ld_addr, st_addr, st_data;
    logic [31:0] rsp_data, address0, dout0, din0, address1, dout1, din1;
    logic        ce0, we0, ce1, we1;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_ld_stall, perf_ld_conflict;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.NUM_REQ(2), .DATA_WIDTH(32), .ADDR_WIDTH(32), .RSP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_ready(ld_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ce0(ce0), .we0(we0), .address0(address0), .dout0(dout0), .din0(din0),
        .ce1(ce1), .we1(we1), .address1(address1), .dout1(dout1), .din1(din1)
`ifdef MEM_ARB_PERF_EN
        , .perf_ld_stall(perf_ld_stall), .perf_ld_conflict(perf_ld_conflict)
`endif
    );

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] bram [32];
    logic [31:0] bram_rd;
    bit          bram_rd_vld;

    logic [31:0] mem_m [32];
    int          ld_ptr, st_ptr;
    int          q_tag[$];
    logic [31:0] q_data[$];
    bit          m_inflight;
    int          m_inf_tag;
    logic [31:0] m_inf_data;
    longint      m_stall, m_conflict;
    int          e_ld, e_st;
    bit          e_pop;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int pick(input logic [1:0] v, input int ptr);
        for (int k = 0; k < NR; k++) begin
            int idx = (ptr + k) % NR;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        q_tag.delete();
        q_data.delete();
        m_inflight = 0;
        ld_ptr = 0;
        st_ptr = 0;
        m_stall = 0;
        m_conflict = 0;
    endtask

    task automatic eval();
        logic [1:0]  e_rv, e_ldr, e_str;
        logic [31:0] e_rd, e_a0, e_a1, e_d1;
        din0 = bram_rd_vld ? bram_rd : $urandom;
        #2;
        e_ld = -1; e_st = -1; e_pop = 0; e_rv = '0; e_rd = '0;
        if (rst) begin
            if (q_tag.size() > 0) begin
                e_rv  = 2'(1 << q_tag[0]);
                e_rd  = q_data[0];
                e_pop = rsp_ready[q_tag[0]];
            end
            if (q_tag.size() + int'(m_inflight) < DEPTH + int'(e_pop)) e_ld = pick(ld_valid, ld_ptr);
            e_st = pick(st_valid, st_ptr);
        end
        e_ldr = (e_ld >= 0) ? 2'(1 << e_ld) : 2'b00;
        e_a0  = (e_ld >= 0) ? ld_addr[e_ld*32 +: 32] : 32'h0;
        e_str = (e_st >= 0) ? 2'(1 << e_st) : 2'b00;
        e_a1  = (e_st >= 0) ? st_addr[e_st*32 +: 32] : 32'h0;
        e_d1  = (e_st >= 0) ? st_data[e_st*32 +: 32] : 32'h0;
        check("ld_ready", ld_ready, e_ldr);
        check("ce0", ce0, e_ld >= 0);
        check("we0", we0, 0);
        check("address0", address0, e_a0);
        check("dout0", dout0, 0);
        check("st_ready", st_ready, e_str);
        check("ce1", ce1, e_st >= 0);
        check("we1", we1, e_st >= 0);
        check("address1", address1, e_a1);
        check("dout1", dout1, e_d1);
        check("rsp_valid", rsp_valid, e_rv);
        if (e_rv != 0) check("rsp_data", rsp_data, e_rd);
`ifdef MEM_ARB_PERF_EN
        check("perf_ld_stall", perf_ld_stall, m_stall);
        check("perf_ld_conflict", perf_ld_conflict, m_conflict);
`endif
    endtask

    task automatic advance();
        logic [31:0] nxt_rd;
        bit          nxt_vld;
        nxt_vld = 0;
        nxt_rd  = '0;
        if (ce0) begin
            nxt_vld = 1;
            nxt_rd  = bram[address0[4:0]];
        end
        if (ce1 && we1) bram[address1[4:0]] = dout1;
        if (!rst) begin
            model_reset();
        end else begin
            if (ld_valid != 0 && e_ld < 0) m_stall++;
            if ($countones(ld_valid) > 1) m_conflict++;
            if (e_pop) begin
                void'(q_tag.pop_front());
                void'(q_data.pop_front());
            end
            if (m_inflight) begin
                q_tag.push_back(m_inf_tag);
                q_data.push_back(m_inf_data);
            end
            m_inflight = (e_ld >= 0);
            if (e_ld >= 0) begin
                m_inf_tag  = e_ld;
                m_inf_data = mem_m[ld_addr[e_ld*32 +: 5]];
                ld_ptr     = (e_ld + 1) % NR;
            end
            if (e_st >= 0) begin
                mem_m[st_addr[e_st*32 +: 5]] = st_data[e_st*32 +: 32];
                st_ptr = (e_st + 1) % NR;
            end
        end
        @(posedge clk);
        #1;
        bram_rd     = nxt_rd;
        bram_rd_vld = nxt_vld;
    endtask

    task automatic cycle();
        eval();
        advance();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
    endtask

    task automatic idle(input int n);
        ld_valid = '0;
        st_valid = '0;
        rsp_ready = 2'b11;
        repeat (n) cycle();
    endtask

    initial begin
        int g_cnt;
        for (int i = 0; i < 32; i++) begin
            bram[i]  = 32'hA000_0000 + i;
            mem_m[i] = 32'hA000_0000 + i;
        end
        bram[16]  = 32'h0000_CAFE;
        mem_m[16] = 32'h0000_CAFE;
        ld_valid = '0; ld_addr = '0; rsp_ready = '0;
        st_valid = '0; st_addr = '0; st_data = '0; din1 = '0;
        bram_rd = '0; bram_rd_vld = 0;
        model_reset();
        e_ld = -1; e_st = -1; e_pop = 0;
        #1;
        repeat (2) cycle();
        rst = 1'b1;

        // single load
        ld_valid = 2'b01; ld_addr = 64'h10; rsp_ready = 2'b11;
        eval();
        check("t2_ld_ready", ld_ready, 2'b01);
        check("t2_ce0", ce0, 1);
        check("t2_addr0", address0, 32'h10);
        advance();
        ld_valid = 2'b00;
        eval();
        check("t2_rsp_early", rsp_valid, 2'b00);
        advance();
        eval();
        check("t2_rsp_valid", rsp_valid, 2'b01);
        check("t2_rsp_data", rsp_data, 32'h0000_CAFE);
        advance();
        idle(2);

        // contention with full acceptance
        do_reset();
        ld_valid = 2'b11; ld_addr = {32'd2, 32'd1}; rsp_ready = 2'b11;
        for (int c = 0; c < 6; c++) begin
            if (c == 4) ld_valid = 2'b00;
            eval();
            if (c < 4) check("t3_grant", ld_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
            if (c >= 2) begin
                check("t3_rsp_owner", rsp_valid, (c % 2 == 0) ? 2'b01 : 2'b10);
                check("t3_rsp_data", rsp_data, (c % 2 == 0) ? 32'hA000_0001 : 32'hA000_0002);
            end
            advance();
        end
        idle(2);

        // backpressure then release
        ld_valid = 2'b01; ld_addr = 64'd3; rsp_ready = 2'b00;
        g_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            eval();
            if (ld_ready != 0) g_cnt++;
            if (c == 3) begin
                check("t4_stalled_ready", ld_ready, 2'b00);
                check("t4_stalled_ce0", ce0, 0);
            end
            advance();
        end
        check("t4_grant_count", g_cnt, 2);
        rsp_ready = 2'b01;
        eval();
        check("t4_resume_grant", ld_ready, 2'b01);
        check("t4_resume_rsp", rsp_valid, 2'b01);
        advance();
        eval();
        check("t4_second_grant", ld_ready, 2'b01);
        advance();
        idle(4);

        // store and load same address in one cycle: read-first
        st_valid = 2'b01; st_addr = 64'd5; st_data = 64'h1;
        ld_valid = 2'b10; ld_addr = {32'd5, 32'd0}; rsp_ready = 2'b11;
        eval();
        check("t5_ce0", ce0, 1);
        check("t5_ce1", ce1, 1);
        check("t5_we1", we1, 1);
        check("t5_ld_ready", ld_ready, 2'b10);
        advance();
        st_valid = 2'b00; ld_valid = 2'b00;
        cycle();
        eval();
        check("t5_old_owner", rsp_valid, 2'b10);
        check("t5_old_data", rsp_data, 32'hA000_0005);
        advance();
        ld_valid = 2'b10;
        cycle();
        ld_valid = 2'b00;
        cycle();
        eval();
        check("t5_new_data", rsp_data, 32'h1);
        advance();
        idle(2);

`ifdef MEM_ARB_PERF_EN
        do_reset();
        rsp_ready = 2'b00; ld_valid = 2'b01; ld_addr = {32'd7, 32'd6};
        repeat (2) cycle();
        ld_valid = 2'b00;
        cycle();
        ld_valid = 2'b11;
        repeat (3) cycle();
        ld_valid = 2'b00;
        eval();
        check("t6_stall", perf_ld_stall, 32'd3);
        check("t6_conflict", perf_ld_conflict, 32'd3);
        advance();
        idle(4);
`endif

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            ld_valid  = 2'($urandom);
            st_valid  = 2'($urandom);
            rsp_ready = 2'($urandom) | ($urandom_range(0, 1) ? 2'b11 : 2'b00);
            ld_addr   = {32'($urandom_range(0, 7)), 32'($urandom_range(0, 7))};
            st_addr   = {32'($urandom_range(0, 7)), 32'($urandom_range(0, 7))};
            st_data   = {32'($urandom), 32'($urandom)};
            cycle();
        end

        // reset with the response FIFO full
        st_valid = 2'b00; ld_valid = 2'b11; rsp_ready = 2'b00;
        repeat (4) cycle();
        eval();
        check("t1_full_before", rsp_valid != 0, 1);
        rst = 1'b0;
        #1;
        check("t1_ld_ready", ld_ready, 2'b00);
        check("t1_ce0", ce0, 0);
        check("t1_addr0", address0, 0);
        check("t1_rsp_valid", rsp_valid, 2'b00);
        check("t1_ce1", ce1, 0);
        advance();
        rst = 1'b1;
        ld_valid = 2'b00;
        eval();
        check("t1_no_stale", rsp_valid, 2'b00);
        advance();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
